// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) over one ready-handshaked memory port.
// Controls are decoded from state and stable IR fields; bus timeouts and illegal opcodes fault, SYSTEM halts.
module mc_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             iszero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       memsize,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             pcsrc,
    output logic             jumpsrc,
    output logic [1:0]       alusrc,
    output logic             alusrc_a_zero,
    output logic [3:0]       alucontrol,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             hlt,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT} state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic       is_imm, is_op, is_system, is_jump, legal;
    logic       taken, timeout, retire;
    logic [3:0] alu_dec;
    logic       unused_funct7;

    assign is_lui    = (op == OP_LUI);
    assign is_auipc  = (op == OP_AUIPC);
    assign is_jal    = (op == OP_JAL);
    assign is_jalr   = (op == OP_JALR);
    assign is_branch = (op == OP_BRANCH);
    assign is_load   = (op == OP_LOAD);
    assign is_store  = (op == OP_STORE);
    assign is_imm    = (op == OP_IMM);
    assign is_op     = (op == OP_OP);
    assign is_system = (op == OP_SYSTEM);
    assign is_jump   = is_jal | is_jalr;
    assign legal     = is_lui | is_auipc | is_jump | is_branch | is_load | is_store | is_imm | is_op;

    // BNE/BLT/BLTU invert the zero flag: funct3 001, 100, 110
    assign taken   = iszero ^ (funct3[2] ^ funct3[0]);
    assign timeout = (wait_cnt == WAIT_LAST) && !mem_ready;
    assign retire  = ((state == S_EXEC) && is_branch)
                   || ((state == S_MEM) && is_store && mem_ready)
                   || (state == S_WB);
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_dec = ALU_ADD;
        if (is_branch) begin
            if (!funct3[2])      alu_dec = ALU_SUB;
            else if (!funct3[1]) alu_dec = ALU_SLT;
            else                 alu_dec = ALU_SLTU;
        end else if (is_op || is_imm) begin
            case (funct3)
                3'b000:  alu_dec = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_dec = ALU_SLL;
                3'b010:  alu_dec = ALU_SLT;
                3'b011:  alu_dec = ALU_SLTU;
                3'b100:  alu_dec = ALU_XOR;
                3'b101:  alu_dec = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_dec = ALU_OR;
                default: alu_dec = ALU_AND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            if (retire)
                instret <= instret + CNT_W'(1);
            if ((state == S_FETCH) || (state == S_MEM)) begin
                if (mem_ready)     wait_cnt <= '0;
                else if (!timeout) wait_cnt <= wait_cnt + 8'd1;
            end
            case (state)
                S_FETCH: begin
                    if (mem_ready)    state <= S_DECODE;
                    else if (timeout) state <= S_FAULT;
                end
                S_DECODE: begin
                    if (is_system)  state <= S_HALT;
                    else if (legal) state <= S_EXEC;
                    else            state <= S_FAULT;
                end
                S_EXEC: begin
                    if (is_branch)                state <= S_FETCH;
                    else if (is_load || is_store) state <= S_MEM;
                    else                          state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready)    state <= is_store ? S_FETCH : S_WB;
                    else if (timeout) state <= S_FAULT;
                end
                S_WB:    state <= S_FETCH;
                default: state <= state;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        memsize       = 3'b000;
        irwrite       = 1'b0;
        pcwrite       = 1'b0;
        pcsrc         = 1'b0;
        jumpsrc       = 1'b0;
        alusrc        = 2'd0;
        alusrc_a_zero = 1'b0;
        alucontrol    = ALU_ADD;
        memtoreg      = 1'b0;
        regwrite      = 1'b0;
        hlt           = 1'b0;
        fault         = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    memsize = 3'b010;
                    irwrite = mem_ready;
                end
                S_EXEC: begin
                    alucontrol    = alu_dec;
                    alusrc        = (is_op || is_branch) ? 2'd0 : 2'd1;
                    alusrc_a_zero = is_lui;
                    if (is_branch) begin
                        pcwrite = 1'b1;
                        pcsrc   = taken;
                    end else if (is_jump) begin
                        pcwrite = 1'b1;
                        pcsrc   = 1'b1;
                        jumpsrc = is_jalr;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    memsize = funct3;
                    pcwrite = is_store && mem_ready;
                end
                S_WB: begin
                    regwrite = 1'b1;
                    memtoreg = is_load;
                    // jumps already redirected the PC in EXEC; WB only writes the link
                    if (is_jump) alusrc  = 2'd2;
                    else         pcwrite = 1'b1;
                end
                S_HALT:  hlt   = 1'b1;
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: table of instructions through a scoreboard queue plus reset/timeout/halt/fault sequences.
module tb_mc_controller;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             iszero;
    logic             mem_ready;
    logic             mem_req, mem_we, irwrite, pcwrite, pcsrc, jumpsrc;
    logic [2:0]       memsize;
    logic [1:0]       alusrc;
    logic             alusrc_a_zero;
    logic [3:0]       alucontrol;
    logic             memtoreg, regwrite, hlt, fault;
    logic [CNT_W-1:0] instret;

    mc_controller #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .iszero(iszero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .memsize(memsize), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
        .jumpsrc(jumpsrc), .alusrc(alusrc), .alusrc_a_zero(alusrc_a_zero),
        .alucontrol(alucontrol), .memtoreg(memtoreg), .regwrite(regwrite),
        .hlt(hlt), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    // alu = -1: not checked; jsrc = -1: not a jump
    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic z; int mwait;
        int cyc; int alu; int pcsrc; int jsrc; int regw; int m2r; int msize;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];
    vec_t exp_q [$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH; fetch accepted at once, MEM accepted after mwait stall cycles.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, memcnt = 0, pcw = 0, regw = 0;
        int o_alu = -1, o_pcsrc = -1, o_jsrc = -1, o_m2r = -1, o_wbsrc = -1;
        bit done = 0, msize_ok = 1;
        logic [CNT_W-1:0] start;
        vec_t e;
        exp_q.push_back(v);
        op = v.op; funct3 = v.f3; funct7 = v.f7; iszero = v.z;
        start = instret;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req && cyc > 1) begin
                mem_ready = (memcnt >= v.mwait);
                memcnt++;
            end else begin
                mem_ready = mem_req;
            end
            #1;
            if (cyc == 3) o_alu = int'(alucontrol);
            if (pcwrite) begin pcw++; o_pcsrc = int'(pcsrc); o_jsrc = int'(jumpsrc); end
            if (regwrite) begin regw++; o_m2r = int'(memtoreg); o_wbsrc = int'(alusrc); end
            if (mem_req && cyc > 1 && int'(memsize) != v.msize) msize_ok = 0;
            @(posedge clk);
            #1;
            if (instret != start) done = 1;
        end
        mem_ready = 1'b0;
        e = exp_q.pop_front();
        chk($sformatf("v%0d retired", idx), int'(done), 1);
        chk($sformatf("v%0d cycles", idx), cyc, e.cyc);
        chk($sformatf("v%0d instret delta", idx), int'(instret - start), 1);
        chk($sformatf("v%0d pcwrite pulses", idx), pcw, 1);
        chk($sformatf("v%0d pcsrc", idx), o_pcsrc, e.pcsrc);
        chk($sformatf("v%0d regwrite pulses", idx), regw, e.regw);
        chk($sformatf("v%0d memsize held", idx), int'(msize_ok), 1);
        if (e.alu >= 0) chk($sformatf("v%0d alucontrol", idx), o_alu, e.alu);
        if (e.regw > 0) chk($sformatf("v%0d memtoreg", idx), o_m2r, e.m2r);
        if (e.jsrc >= 0) begin
            chk($sformatf("v%0d jumpsrc", idx), o_jsrc, e.jsrc);
            chk($sformatf("v%0d link alusrc", idx), o_wbsrc, 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          op          f3      f7          z    mw cyc alu pcsrc jsrc regw m2r msize
        vecs[0]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 4,  0,  0,  -1,  1,  0,  0}; // ADD
        vecs[1]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 4,  1,  0,  -1,  1,  0,  0}; // SUB
        vecs[2]  = '{7'b0110011, 3'b101, 7'b0100000, 1'b0, 0, 4,  7,  0,  -1,  1,  0,  0}; // SRA
        vecs[3]  = '{7'b0110011, 3'b101, 7'b0000000, 1'b0, 0, 4,  6,  0,  -1,  1,  0,  0}; // SRL
        vecs[4]  = '{7'b0110011, 3'b011, 7'b0000000, 1'b0, 0, 4,  4,  0,  -1,  1,  0,  0}; // SLTU
        vecs[5]  = '{7'b0010011, 3'b101, 7'b0100000, 1'b0, 0, 4,  7,  0,  -1,  1,  0,  0}; // SRAI
        vecs[6]  = '{7'b0010011, 3'b000, 7'b0100000, 1'b0, 0, 4,  0,  0,  -1,  1,  0,  0}; // ADDI, f7[5] ignored
        vecs[7]  = '{7'b0010011, 3'b111, 7'b0000000, 1'b0, 0, 4,  9,  0,  -1,  1,  0,  0}; // ANDI
        vecs[8]  = '{7'b0010011, 3'b110, 7'b0000000, 1'b0, 0, 4,  8,  0,  -1,  1,  0,  0}; // ORI
        vecs[9]  = '{7'b0010011, 3'b100, 7'b0000000, 1'b0, 0, 4,  5,  0,  -1,  1,  0,  0}; // XORI
        vecs[10] = '{7'b0010011, 3'b001, 7'b0000000, 1'b0, 0, 4,  2,  0,  -1,  1,  0,  0}; // SLLI
        vecs[11] = '{7'b0010011, 3'b010, 7'b0000000, 1'b0, 0, 4,  3,  0,  -1,  1,  0,  0}; // SLTI
        vecs[12] = '{7'b0110111, 3'b000, 7'b0000000, 1'b0, 0, 4,  0,  0,  -1,  1,  0,  0}; // LUI
        vecs[13] = '{7'b0010111, 3'b000, 7'b0000000, 1'b0, 0, 4,  0,  0,  -1,  1,  0,  0}; // AUIPC
        vecs[14] = '{7'b0000011, 3'b010, 7'b0000000, 1'b0, 3, 8,  0,  0,  -1,  1,  1,  2}; // LW, 3 waits
        vecs[15] = '{7'b0000011, 3'b000, 7'b0000000, 1'b0, 0, 5,  0,  0,  -1,  1,  1,  0}; // LB
        vecs[16] = '{7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 4,  0,  0,  -1,  0,  0,  2}; // SW
        vecs[17] = '{7'b0100011, 3'b001, 7'b0000000, 1'b0, 2, 6,  0,  0,  -1,  0,  0,  1}; // SH, 2 waits
        vecs[18] = '{7'b1100011, 3'b001, 7'b0000000, 1'b0, 0, 3,  1,  1,  -1,  0,  0,  0}; // BNE z=0
        vecs[19] = '{7'b1100011, 3'b101, 7'b0000000, 1'b0, 0, 3,  3,  0,  -1,  0,  0,  0}; // BGE z=0
        vecs[20] = '{7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 3,  1,  1,  -1,  0,  0,  0}; // BEQ z=1
        vecs[21] = '{7'b1100011, 3'b110, 7'b0000000, 1'b0, 0, 3,  4,  1,  -1,  0,  0,  0}; // BLTU z=0
        vecs[22] = '{7'b1100011, 3'b111, 7'b0000000, 1'b1, 0, 3,  4,  1,  -1,  0,  0,  0}; // BGEU z=1
        vecs[23] = '{7'b1101111, 3'b000, 7'b0000000, 1'b0, 0, 4, -1,  1,   0,  1,  0,  0}; // JAL
        vecs[24] = '{7'b1100111, 3'b000, 7'b0000000, 1'b0, 0, 4, -1,  1,   1,  1,  0,  0}; // JALR

        reset = 1'b1; op = '0; funct3 = '0; funct7 = '0; iszero = 1'b0; mem_ready = 1'b0;
        do_reset();
        #1;
        chk("reset mem_req", int'(mem_req), 1);
        chk("reset memsize", int'(memsize), 2);
        chk("reset mem_we", int'(mem_we), 0);
        chk("reset regwrite", int'(regwrite), 0);
        chk("reset pcwrite", int'(pcwrite), 0);
        chk("reset hlt", int'(hlt), 0);
        chk("reset fault", int'(fault), 0);
        chk("reset instret", int'(instret), 0);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);
        chk("instret after table", int'(instret), NV);
        chk("scoreboard drained", exp_q.size(), 0);

        // fetch timeout: fault exactly 15 cycles after FETCH entry
        do_reset();
        #1;
        n = 0;
        while (!fault && n < 40) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            n++;
        end
        chk("timeout cycles", n, 15);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            chk("fault sticky", int'(fault), 1);
            chk("fault strobes", int'({mem_req, irwrite, pcwrite, regwrite, mem_we}), 0);
        end
        chk("fault instret", int'(instret), 0);

        // illegal opcode
        do_reset();
        op = 7'b1111111;
        mem_ready = 1'b1;
        #1;
        chk("illegal irwrite", int'(irwrite), 1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("illegal decode fault", int'(fault), 0);
        @(negedge clk);
        #1;
        chk("illegal fault", int'(fault), 1);
        chk("illegal hlt", int'(hlt), 0);
        chk("illegal instret", int'(instret), 0);

        // ECALL halts without retiring
        do_reset();
        run_vec(100, vecs[0]);
        op = 7'b1110011; funct3 = 3'b000; funct7 = 7'b0000000;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("ecall hlt", int'(hlt), 1);
        chk("ecall fault", int'(fault), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            chk("halt strobes", int'({mem_req, irwrite, pcwrite, regwrite}), 0);
            chk("halt sticky", int'(hlt), 1);
        end
        chk("ecall instret", int'(instret), 1);

        // reset during a stalled store in MEM
        do_reset();
        run_vec(101, vecs[0]);
        op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("store mem_we before reset", int'(mem_we), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-reset mem_we", int'(mem_we), 0);
        chk("post-reset fetch req", int'(mem_req), 1);
        chk("post-reset memsize", int'(memsize), 2);
        chk("post-reset pcwrite", int'(pcwrite), 0);
        chk("post-reset regwrite", int'(regwrite), 0);
        chk("post-reset instret", int'(instret), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
